// File: rtl/difftest_commit_source_pkg.sv
// Shared types and constants for the difftest commit source: the retire
// record carried through the FIFO, the run/halt state and a small helper
// that decides whether a record updates the shadow register file.
package difftest_pkg;

    localparam int DATA_W  = 64;
    localparam int NUM_GPR = 32;
    localparam int GPR_AW  = 5;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] debug_pc;
        logic              rd_wen;
        logic [GPR_AW-1:0] rd_addr;
        logic [DATA_W-1:0] rd_wdata;
        logic              timer_int;
        logic              out_int;
        logic              ebreak;
    } retire_rec_t;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    // x0 is hardwired to zero, so a write to it never lands in the shadow file.
    function automatic logic gpr_write_en(input retire_rec_t rec);
        return rec.rd_wen & (rec.rd_addr != {GPR_AW{1'b0}});
    endfunction

endpackage

// File: rtl/difftest_commit_source_if.sv
// Retire handshake between the writeback stage (master) and the commit
// source (slave). The slave drives retire_ready; everything else flows in.
interface difftest_commit_source_if;
    import difftest_pkg::*;

    logic                retire_valid;
    logic                retire_ready;
    logic [DATA_W-1:0]   retire_pc;
    logic [DATA_W-1:0]   retire_debug_pc;
    logic                retire_rd_wen;
    logic [GPR_AW-1:0]   retire_rd_addr;
    logic [DATA_W-1:0]   retire_rd_wdata;
    logic                retire_timer_int;
    logic                retire_out_int;
    logic                retire_ebreak;

    modport master (
        output retire_valid, retire_pc, retire_debug_pc, retire_rd_wen,
               retire_rd_addr, retire_rd_wdata, retire_timer_int,
               retire_out_int, retire_ebreak,
        input  retire_ready
    );

    modport slave (
        input  retire_valid, retire_pc, retire_debug_pc, retire_rd_wen,
               retire_rd_addr, retire_rd_wdata, retire_timer_int,
               retire_out_int, retire_ebreak,
        output retire_ready
    );

endinterface

// File: rtl/difftest_commit_source_commit_fifo.sv
// Synchronous FIFO of retire records. Pointers carry one extra wrap bit so
// full and empty are distinguishable. Read data is the head entry with no
// bypass: a pushed entry becomes visible one edge after the push.
module commit_fifo
    import difftest_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        push,
    input  retire_rec_t wdata,
    input  logic        pop,
    output retire_rec_t rdata,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    retire_rec_t   mem_q [DEPTH];
    retire_rec_t   mem_d [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_push_s;
    logic          do_pop_s;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push_s = push & ~full & ~flush;
    assign do_pop_s  = pop & ~empty & ~flush;

    // Next pointer and storage values; a flush discards all queued entries.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = {(AW+1){1'b0}};
            rd_ptr_d = {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q[AW-1:0]] = wdata;
                wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // Pointer and storage registers, fully cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/difftest_commit_source.sv
// Commit source for the difftest monitor: queues retire records, replays
// them one per cycle while the monitor is ready, mirrors GPR writes into a
// shadow register file and stops for good after emitting an ebreak.
module difftest_commit_source
    import difftest_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    difftest_commit_source_if.slave    retire,
    input  logic                       monitor_ready,
    output logic                       inst_commit,
    output logic [DATA_W-1:0]          pc,
    output logic [DATA_W-1:0]          debug_pc,
    output logic [DATA_W*NUM_GPR-1:0]  gpr_wire,
    output logic                       cpu_timer_int,
    output logic                       cpu_out_int,
    output logic                       cpu_ebreak_sign,
    output logic                       halted,
    output logic [63:0]                commit_count
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] debug_pc_q, debug_pc_d;
    logic              inst_commit_q, inst_commit_d;
    logic              timer_int_q, timer_int_d;
    logic              out_int_q, out_int_d;
    logic              ebreak_q, ebreak_d;
    logic              halted_q, halted_d;
    logic [63:0]       commit_count_q, commit_count_d;
    logic [DATA_W-1:0] gpr_q [NUM_GPR];
    logic [DATA_W-1:0] gpr_d [NUM_GPR];

    retire_rec_t       push_rec_s;
    retire_rec_t       head_s;
    logic              full_s;
    logic              empty_s;
    logic              running_s;
    logic              push_s;
    logic              pop_s;

    assign running_s           = (state_q == ST_RUN);
    assign retire.retire_ready = ~full_s & running_s;
    assign push_s              = retire.retire_valid & ~full_s & running_s;
    assign pop_s               = ~empty_s & monitor_ready & running_s;

    assign push_rec_s.pc        = retire.retire_pc;
    assign push_rec_s.debug_pc  = retire.retire_debug_pc;
    assign push_rec_s.rd_wen    = retire.retire_rd_wen;
    assign push_rec_s.rd_addr   = retire.retire_rd_addr;
    assign push_rec_s.rd_wdata  = retire.retire_rd_wdata;
    assign push_rec_s.timer_int = retire.retire_timer_int;
    assign push_rec_s.out_int   = retire.retire_out_int;
    assign push_rec_s.ebreak    = retire.retire_ebreak;

    commit_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clock),
        .rst_n (reset),
        .flush (~running_s),
        .push  (push_s),
        .wdata (push_rec_s),
        .pop   (pop_s),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Run/halt sequencing: emitting an ebreak is terminal until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (pop_s && head_s.ebreak) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
        halted_d = (state_d == ST_HALT);
    end

    // Emitted-record outputs: fields hold, pulses fire only on a pop edge.
    always_comb begin
        pc_d           = pc_q;
        debug_pc_d     = debug_pc_q;
        inst_commit_d  = 1'b0;
        timer_int_d    = 1'b0;
        out_int_d      = 1'b0;
        ebreak_d       = 1'b0;
        commit_count_d = commit_count_q;
        gpr_d          = gpr_q;
        if (pop_s) begin
            pc_d           = head_s.pc;
            debug_pc_d     = head_s.debug_pc;
            inst_commit_d  = 1'b1;
            timer_int_d    = head_s.timer_int;
            out_int_d      = head_s.out_int;
            ebreak_d       = head_s.ebreak;
            commit_count_d = commit_count_q + 64'd1;
            if (gpr_write_en(head_s)) begin
                gpr_d[head_s.rd_addr] = head_s.rd_wdata;
            end else begin
                gpr_d = gpr_q;
            end
        end else begin
            pc_d = pc_q;
        end
        gpr_d[0] = {DATA_W{1'b0}};
    end

    // State, output and shadow-GPR registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_RUN;
            pc_q           <= {DATA_W{1'b0}};
            debug_pc_q     <= {DATA_W{1'b0}};
            inst_commit_q  <= 1'b0;
            timer_int_q    <= 1'b0;
            out_int_q      <= 1'b0;
            ebreak_q       <= 1'b0;
            halted_q       <= 1'b0;
            commit_count_q <= 64'd0;
            for (int i = 0; i < NUM_GPR; i++) begin
                gpr_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            debug_pc_q     <= debug_pc_d;
            inst_commit_q  <= inst_commit_d;
            timer_int_q    <= timer_int_d;
            out_int_q      <= out_int_d;
            ebreak_q       <= ebreak_d;
            halted_q       <= halted_d;
            commit_count_q <= commit_count_d;
            gpr_q          <= gpr_d;
        end
    end

    for (genvar g = 0; g < NUM_GPR; g++) begin : g_gpr_flat
        assign gpr_wire[g*DATA_W +: DATA_W] = gpr_q[g];
    end

    assign pc              = pc_q;
    assign debug_pc        = debug_pc_q;
    assign inst_commit     = inst_commit_q;
    assign cpu_timer_int   = timer_int_q;
    assign cpu_out_int     = out_int_q;
    assign cpu_ebreak_sign = ebreak_q;
    assign halted          = halted_q;
    assign commit_count    = commit_count_q;

endmodule

// File: tb/tb_difftest_commit_source.sv
// Directed bench for difftest_commit_source: a vector table of single
// records with hand-computed results, plus sequences for backpressure,
// ebreak halt and reset while entries are queued.
module tb_difftest_commit_source;
    import difftest_pkg::*;

    logic                      clock;
    logic                      reset;
    logic                      monitor_ready;
    logic                      inst_commit;
    logic [DATA_W-1:0]         pc;
    logic [DATA_W-1:0]         debug_pc;
    logic [DATA_W*NUM_GPR-1:0] gpr_wire;
    logic                      cpu_timer_int;
    logic                      cpu_out_int;
    logic                      cpu_ebreak_sign;
    logic                      halted;
    logic [63:0]               commit_count;

    int tests  = 0;
    int failed = 0;

    difftest_commit_source_if rif ();

    difftest_commit_source #(.DEPTH(4)) dut (
        .clock           (clock),
        .reset           (reset),
        .retire          (rif.slave),
        .monitor_ready   (monitor_ready),
        .inst_commit     (inst_commit),
        .pc              (pc),
        .debug_pc        (debug_pc),
        .gpr_wire        (gpr_wire),
        .cpu_timer_int   (cpu_timer_int),
        .cpu_out_int     (cpu_out_int),
        .cpu_ebreak_sign (cpu_ebreak_sign),
        .halted          (halted),
        .commit_count    (commit_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] pc;
        logic        wen;
        logic [4:0]  rd;
        logic [63:0] wdata;
        logic        tint;
        logic        oint;
        logic [4:0]  exp_idx;
        logic [63:0] exp_gpr;
        logic [63:0] exp_count;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_rec(input logic [63:0] p, input logic wen, input logic [4:0] rd,
                           input logic [63:0] wd, input logic ti, input logic oi,
                           input logic eb);
        rif.retire_pc        = p;
        rif.retire_debug_pc  = p + 64'd4;
        rif.retire_rd_wen    = wen;
        rif.retire_rd_addr   = rd;
        rif.retire_rd_wdata  = wd;
        rif.retire_timer_int = ti;
        rif.retire_out_int   = oi;
        rif.retire_ebreak    = eb;
    endtask

    function automatic logic [63:0] gpr(input int idx);
        return gpr_wire[idx*64 +: 64];
    endfunction

    initial begin
        int commits;
        int ebs;
        logic accepted;

        vecs[0] = '{64'h8000_0000, 1'b1, 5'd5,  64'h1234,              1'b0, 1'b0, 5'd5,  64'h1234,              64'd1};
        vecs[1] = '{64'h8000_0004, 1'b1, 5'd0,  64'hFFFF,              1'b0, 1'b0, 5'd0,  64'h0,                 64'd2};
        vecs[2] = '{64'h8000_0008, 1'b0, 5'd5,  64'hDEAD,              1'b0, 1'b0, 5'd5,  64'h1234,              64'd3};
        vecs[3] = '{64'h8000_0010, 1'b1, 5'd31, 64'hA5A5_5A5A_0F0F_F0F0, 1'b1, 1'b0, 5'd31, 64'hA5A5_5A5A_0F0F_F0F0, 64'd4};
        vecs[4] = '{64'h8000_0014, 1'b1, 5'd1,  64'h1,                 1'b0, 1'b1, 5'd1,  64'h1,                 64'd5};

        reset            = 1'b0;
        monitor_ready    = 1'b1;
        rif.retire_valid = 1'b0;
        set_rec(64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_commit", {63'd0, inst_commit}, 64'd0);
        chk("rst_pc", pc, 64'd0);
        chk("rst_count", commit_count, 64'd0);
        chk("rst_halted", {63'd0, halted}, 64'd0);
        reset = 1'b1;
        tick();
        chk("ready_after_rst", {63'd0, rif.retire_ready}, 64'd1);

        // Table: one record at a time, two-edge latency, one-cycle pulse.
        for (int i = 0; i < 5; i++) begin
            set_rec(vecs[i].pc, vecs[i].wen, vecs[i].rd, vecs[i].wdata, vecs[i].tint, vecs[i].oint, 1'b0);
            rif.retire_valid = 1'b1;
            tick();
            rif.retire_valid = 1'b0;
            chk($sformatf("v%0d_no_bypass", i), {63'd0, inst_commit}, 64'd0);
            tick();
            chk($sformatf("v%0d_commit", i), {63'd0, inst_commit}, 64'd1);
            chk($sformatf("v%0d_pc", i), pc, vecs[i].pc);
            chk($sformatf("v%0d_dpc", i), debug_pc, vecs[i].pc + 64'd4);
            chk($sformatf("v%0d_tint", i), {63'd0, cpu_timer_int}, {63'd0, vecs[i].tint});
            chk($sformatf("v%0d_oint", i), {63'd0, cpu_out_int}, {63'd0, vecs[i].oint});
            chk($sformatf("v%0d_ebreak", i), {63'd0, cpu_ebreak_sign}, 64'd0);
            chk($sformatf("v%0d_gpr", i), gpr(vecs[i].exp_idx), vecs[i].exp_gpr);
            chk($sformatf("v%0d_count", i), commit_count, vecs[i].exp_count);
            tick();
            chk($sformatf("v%0d_pulse_clr", i), {61'd0, inst_commit, cpu_timer_int, cpu_out_int}, 64'd0);
            chk($sformatf("v%0d_pc_hold", i), pc, vecs[i].pc);
        end
        chk("gpr0_zero", gpr(0), 64'd0);

        // Backpressure: fill with monitor stalled, then drain in order.
        monitor_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            set_rec(64'h9000_0000 + 64'(j * 4), 1'b1, 5'(10 + j), 64'(100 + j), 1'b0, 1'b0, 1'b0);
            rif.retire_valid = 1'b1;
            chk($sformatf("bp_ready%0d", j), {63'd0, rif.retire_ready}, (j < 4) ? 64'd1 : 64'd0);
            tick();
        end
        chk("bp_held_ready", {63'd0, rif.retire_ready}, 64'd0);
        chk("bp_no_commit", {63'd0, inst_commit}, 64'd0);
        monitor_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            accepted = rif.retire_valid & rif.retire_ready;
            tick();
            if (accepted) rif.retire_valid = 1'b0;
            chk($sformatf("bp_commit%0d", j), {63'd0, inst_commit}, 64'd1);
            chk($sformatf("bp_pc%0d", j), pc, 64'h9000_0000 + 64'(j * 4));
        end
        chk("bp_accepted_5th", {63'd0, rif.retire_valid}, 64'd0);
        tick();
        chk("bp_drained", {63'd0, inst_commit}, 64'd0);
        chk("bp_count", commit_count, 64'd10);
        chk("bp_gpr14", gpr(14), 64'd104);

        // Ebreak followed by two more offers: halts after the ebreak only.
        ebs = 0;
        commits = 0;
        for (int k = 0; k < 3; k++) begin
            set_rec(64'hA000_0000 + 64'(k * 4), 1'b1, 5'd20, 64'(k + 1), 1'b0, 1'b0, (k == 0));
            rif.retire_valid = 1'b1;
            tick();
            if (k == 1) begin
                chk("eb_commit", {63'd0, inst_commit}, 64'd1);
                chk("eb_sign", {63'd0, cpu_ebreak_sign}, 64'd1);
                chk("eb_halted", {63'd0, halted}, 64'd1);
                chk("eb_pc", pc, 64'hA000_0000);
            end
            if (k == 2) chk("eb_ready0", {63'd0, rif.retire_ready}, 64'd0);
        end
        rif.retire_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (inst_commit) commits++;
            if (cpu_ebreak_sign) ebs++;
        end
        chk("eb_no_more_commits", 64'(commits), 64'd0);
        chk("eb_no_more_sign", 64'(ebs), 64'd0);
        chk("eb_count", commit_count, 64'd11);
        chk("eb_pc_hold", pc, 64'hA000_0000);
        chk("eb_halt_hold", {63'd0, halted}, 64'd1);

        // Reset leaves HALT; then reset again with entries queued.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("rs_halted_clr", {63'd0, halted}, 64'd0);
        set_rec(64'hB000_0000, 1'b1, 5'd7, 64'h77, 1'b0, 1'b0, 1'b0);
        rif.retire_valid = 1'b1;
        tick();
        rif.retire_valid = 1'b0;
        tick();
        chk("rs_pre_pc", pc, 64'hB000_0000);
        monitor_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_rec(64'hB000_0100 + 64'(k * 4), 1'b1, 5'd8, 64'h88, 1'b1, 1'b1, 1'b0);
            rif.retire_valid = 1'b1;
            tick();
        end
        rif.retire_valid = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        chk("rs_pc0", pc, 64'd0);
        chk("rs_dpc0", debug_pc, 64'd0);
        chk("rs_count0", commit_count, 64'd0);
        chk("rs_gpr7", gpr(7), 64'd0);
        tick();
        reset = 1'b1;
        monitor_ready = 1'b1;
        commits = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (inst_commit) commits++;
        end
        chk("rs_no_commit", 64'(commits), 64'd0);
        set_rec(64'hC000_0000, 1'b1, 5'd3, 64'h33, 1'b0, 1'b0, 1'b0);
        rif.retire_valid = 1'b1;
        tick();
        rif.retire_valid = 1'b0;
        tick();
        chk("rs_new_commit", {63'd0, inst_commit}, 64'd1);
        chk("rs_new_pc", pc, 64'hC000_0000);
        chk("rs_new_count", commit_count, 64'd1);
        chk("rs_new_gpr3", gpr(3), 64'h33);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
